uart_alu_sequencer: RTL and testbench

- Frame controller between the UART receiver, the ALU and the UART transmitter.
- Collects a three-byte command frame from the receiver: operand A, operand B, opcode.
- Presents the frame to the ALU, captures the result and launches one transmitter byte.
- Holds off further frames until the transmitter reports completion; bounds partial frames with a cycle timeout.

---
 rtl/uart_alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_uart_alu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_sequencer.sv
// Frame controller: gathers A, B and opcode bytes from the UART receiver, drives the ALU,
// launches one transmit byte with the result and waits for the transmitter to finish.
`timescale 1ns/1ps
module uart_alu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic [7:0] alu_result,
    input  logic       tx_done,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [5:0] alu_op,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       rx_overrun,
    output logic       frame_timeout
);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_WAIT_TX
    } state_t;

    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rx_q, rx_d, tx_q, tx_d;
    logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d, tx_data_q, tx_data_d;
    logic [5:0]       alu_op_q, alu_op_d;
    logic             tx_start_q, tx_start_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic             frame_timeout_q, frame_timeout_d;
    logic             rx_rise, tx_rise;

    // Edge detectors reset high so a level already present at reset release is not an event.
    assign rx_rise = rx_done & ~rx_q;
    assign tx_rise = tx_done & ~tx_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rx_d            = rx_done;
        tx_d            = tx_done;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        alu_op_d        = alu_op_q;
        tx_data_d       = tx_data_q;
        tx_start_d      = 1'b0;
        rx_overrun_d    = 1'b0;
        frame_timeout_d = 1'b0;
        case (state_q)
            S_WAIT_A: begin
                if (rx_rise) begin
                    alu_a_d = rx_data;
                    cnt_d   = '0;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B, S_WAIT_OP: begin
                // A byte arriving on the last allowed cycle beats the timeout.
                if (rx_rise) begin
                    cnt_d = '0;
                    if (state_q == S_WAIT_B) begin
                        alu_b_d = rx_data;
                        state_d = S_WAIT_OP;
                    end else begin
                        alu_op_d = rx_data[5:0];
                        state_d  = S_EXEC;
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    cnt_d           = '0;
                    frame_timeout_d = 1'b1;
                    state_d         = S_WAIT_A;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                tx_data_d    = alu_result;
                tx_start_d   = 1'b1;
                rx_overrun_d = rx_rise;
                state_d      = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                rx_overrun_d = rx_rise;
                if (tx_rise) begin
                    state_d = S_WAIT_A;
                end
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_WAIT_A;
            cnt_q           <= '0;
            rx_q            <= 1'b1;
            tx_q            <= 1'b1;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_op_q        <= '0;
            tx_data_q       <= '0;
            tx_start_q      <= 1'b0;
            rx_overrun_q    <= 1'b0;
            frame_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rx_q            <= rx_d;
            tx_q            <= tx_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            alu_op_q        <= alu_op_d;
            tx_data_q       <= tx_data_d;
            tx_start_q      <= tx_start_d;
            rx_overrun_q    <= rx_overrun_d;
            frame_timeout_q <= frame_timeout_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;
    assign tx_data       = tx_data_q;
    assign tx_start      = tx_start_q;
    assign rx_overrun    = rx_overrun_q;
    assign frame_timeout = frame_timeout_q;
    assign busy          = (state_q == S_EXEC) || (state_q == S_WAIT_TX);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: directed frame scenarios plus random frames, checked
// against a frame-level model of the collected operands and the ALU result.
`timescale 1ns/1ps
module tb_uart_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data, alu_result, alu_a, alu_b, tx_data;
    logic       rx_done, tx_done, tx_start, busy, rx_overrun, frame_timeout;
    logic [5:0] alu_op;

    logic [7:0] rx_data_z, alu_result_z, alu_a_z, alu_b_z, tx_data_z;
    logic       rx_done_z, tx_done_z, tx_start_z, busy_z, rx_overrun_z, frame_timeout_z;
    logic [5:0] alu_op_z;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_cnt = 0, to_cnt = 0, to_z_cnt = 0, dbl_cnt = 0;
    bit ov_prev = 1'b0, to_prev = 1'b0;

    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_tx = 8'h00;
    logic [5:0] m_op = 6'h00;

    always #5 clk = ~clk;

    // Stand-in ALU: 0 add, 1 sub, 2 and, 3 xor on opcode[1:0].
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result   = alu_ref(alu_a, alu_b, alu_op);
    assign alu_result_z = alu_ref(alu_a_z, alu_b_z, alu_op_z);

    uart_alu_sequencer #(.TIMEOUT_CYCLES(50), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .alu_result(alu_result), .tx_done(tx_done), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
        .rx_overrun(rx_overrun), .frame_timeout(frame_timeout)
    );

    uart_alu_sequencer #(.TIMEOUT_CYCLES(0), .CNT_W(16)) dut_z (
        .clk(clk), .rst(rst), .rx_data(rx_data_z), .rx_done(rx_done_z),
        .alu_result(alu_result_z), .tx_done(tx_done_z), .alu_a(alu_a_z), .alu_b(alu_b_z),
        .alu_op(alu_op_z), .tx_data(tx_data_z), .tx_start(tx_start_z), .busy(busy_z),
        .rx_overrun(rx_overrun_z), .frame_timeout(frame_timeout_z)
    );

    // Pulse monitor: counts events and any pulse lasting two cycles.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rx_overrun) ov_cnt++;
            if (frame_timeout) to_cnt++;
            if (frame_timeout_z) to_z_cnt++;
            if ((rx_overrun && ov_prev) || (frame_timeout && to_prev)) dbl_cnt++;
        end
        ov_prev = rx_overrun;
        to_prev = frame_timeout;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_alu_a"}, alu_a, 0);
        check_eq({pfx, "_alu_b"}, alu_b, 0);
        check_eq({pfx, "_alu_op"}, alu_op, 0);
        check_eq({pfx, "_tx_data"}, tx_data, 0);
        check_eq({pfx, "_tx_start"}, tx_start, 0);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_rx_overrun"}, rx_overrun, 0);
        check_eq({pfx, "_frame_timeout"}, frame_timeout, 0);
    endtask

    // Called at a negedge; the byte is sampled at the next rising edge and held for 'hold' edges.
    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_tx(input int hold);
        tx_done = 1'b1;
        @(negedge clk);
        check_eq("busy_after_tx", busy, 0);
        repeat (hold - 1) @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input int hold, input int tx_wait, input int tx_hold,
                            input bit stray_tx, input bit finish);
        logic [7:0] exp;
        int ov0, to0;
        ov0 = ov_cnt;
        to0 = to_cnt;
        send_byte(a, hold);
        check_eq("alu_a", alu_a, a);
        check_eq("alu_b_kept", alu_b, m_b);
        m_a = a;
        if (stray_tx) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        send_byte(b, hold);
        check_eq("alu_b", alu_b, b);
        check_eq("alu_op_kept", alu_op, m_op);
        m_b = b;
        exp = alu_ref(a, b, op[5:0]);
        rx_data = op;
        rx_done = 1'b1;
        @(negedge clk);
        check_eq("alu_op", alu_op, op[5:0]);
        check_eq("busy_exec", busy, 1);
        check_eq("tx_start_early", tx_start, 0);
        check_eq("tx_data_old", tx_data, m_tx);
        @(negedge clk);
        check_eq("tx_start", tx_start, 1);
        check_eq("tx_data", tx_data, exp);
        @(negedge clk);
        check_eq("tx_start_off", tx_start, 0);
        check_eq("busy_wait_tx", busy, 1);
        for (int i = 3; i < hold; i++) @(negedge clk);
        rx_done = 1'b0;
        m_op = op[5:0];
        m_tx = exp;
        repeat (tx_wait) @(negedge clk);
        check_eq("busy_hold", busy, 1);
        check_eq("tx_data_stable", tx_data, exp);
        check_eq("no_overrun", ov_cnt, ov0);
        check_eq("no_timeout", to_cnt, to0);
        if (finish) finish_tx(tx_hold);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int ov0, to0;
        logic [7:0] b2, exp2;
        rst = 1'b1;
        rx_data = 0; rx_done = 0; tx_done = 0;
        rx_data_z = 0; rx_done_z = 0; tx_done_z = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Normal frame and held-level frame.
        do_frame(8'h05, 8'h03, 8'h20, 1, 3, 1, 1'b1, 1'b1);
        do_frame(8'hFF, 8'h01, 8'h00, 20, 5, 3, 1'b0, 1'b1);
        check_eq("held_wrap", tx_data, 8'h00);

        // Partial frame timeout, then a byte on the last allowed cycle.
        to0 = to_cnt;
        send_byte(8'h11, 1);
        check_eq("to_alu_a", alu_a, 8'h11);
        m_a = 8'h11;
        for (int i = 1; i <= 51; i++) begin
            if (i > 1) @(negedge clk);
            if (i >= 48) check_eq($sformatf("ft_edge%0d", i), frame_timeout, (i == 50) ? 1 : 0);
        end
        check_eq("to_count", to_cnt, to0 + 1);
        check_eq("to_keep_a", alu_a, m_a);
        check_eq("to_keep_b", alu_b, m_b);
        check_eq("to_keep_op", alu_op, m_op);
        send_byte(8'h22, 1);
        check_eq("after_to_a", alu_a, 8'h22);
        m_a = 8'h22;
        repeat (48) @(negedge clk);
        b2 = 8'($urandom_range(0, 255));
        send_byte(b2, 1);
        check_eq("edge_b", alu_b, b2);
        check_eq("edge_no_to", to_cnt, to0 + 1);
        m_b = b2;
        exp2 = alu_ref(m_a, b2, 6'h03);
        send_byte(8'hC3, 1);
        check_eq("edge_op", alu_op, 6'h03);
        check_eq("edge_tx_start", tx_start, 1);
        check_eq("edge_tx_data", tx_data, exp2);
        m_op = 6'h03;
        m_tx = exp2;
        finish_tx(1);

        // Overruns: one during WAIT_TX, one coincident with the tx_done rise.
        do_frame(8'h9A, 8'h3B, 8'h01, 2, 4, 1, 1'b0, 1'b0);
        ov0 = ov_cnt;
        send_byte(8'h77, 1);
        check_eq("ov1_count", ov_cnt, ov0 + 1);
        check_eq("ov1_alu_a", alu_a, m_a);
        check_eq("ov1_busy", busy, 1);
        rx_data = 8'h99;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        check_eq("ov2_pulse", rx_overrun, 1);
        check_eq("ov2_busy", busy, 0);
        check_eq("ov2_alu_a", alu_a, m_a);
        rx_done = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        check_eq("ov2_pulse_end", rx_overrun, 0);
        check_eq("ov2_count", ov_cnt, ov0 + 2);
        do_frame(8'h40, 8'h0F, 8'h02, 1, 0, 1, 1'b0, 1'b1);

        // Reset in the middle of a frame with rx_done high across the release.
        send_byte(8'hA5, 1);
        ov0 = ov_cnt;
        to0 = to_cnt;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_vals("midrst");
        rx_data = 8'h5A;
        rx_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_no_latch", alu_a, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_no_pulse", ov_cnt + to_cnt, ov0 + to0);
        rx_done = 1'b0;
        m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
        @(negedge clk);

        // Random frames.
        for (int n = 0; n < 10; n++) begin
            do_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), $urandom_range(1, 20),
                     $urandom_range(0, 15), $urandom_range(1, 4),
                     1'($urandom_range(0, 1)), 1'b1);
        end

        // Timeout disabled: long idle in WAIT_B, then the frame completes.
        rx_data_z = 8'h3C; rx_done_z = 1'b1;
        @(negedge clk);
        rx_done_z = 1'b0;
        @(negedge clk);
        check_eq("z_alu_a", alu_a_z, 8'h3C);
        repeat (10000) @(negedge clk);
        check_eq("z_no_timeout", to_z_cnt, 0);
        rx_data_z = 8'h4D; rx_done_z = 1'b1;
        @(negedge clk);
        rx_done_z = 1'b0;
        @(negedge clk);
        check_eq("z_alu_b", alu_b_z, 8'h4D);
        rx_data_z = 8'h01; rx_done_z = 1'b1;
        @(negedge clk);
        rx_done_z = 1'b0;
        @(negedge clk);
        check_eq("z_tx_start", tx_start_z, 1);
        check_eq("z_tx_data", tx_data_z, 8'hEF);
        tx_done_z = 1'b1;
        @(negedge clk);
        tx_done_z = 1'b0;
        check_eq("z_busy_done", busy_z, 0);

        check_eq("pulse_width", dbl_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
